dccm_lsu: RTL and testbench
===========================

Name: dccm_lsu

Overview:
- Load/store initiator that drives the DCCM's single-port, byte-lane-coded interface on behalf of the execute stage.
- Accepts one request per valid/ready handshake and checks alignment and address range.
- Generates DCCM byte_enable, word address and write/read strobes for exactly one access cycle.
- Returns extracted, sign- or zero-extended load data, or a store completion, on a backpressurable response channel.

Parameters:
- DataWidth, 32, data width; only 32 is supported.
- AddrWidth, 15, DCCM word-address width; byte space is 2^(AddrWidth+2) bytes.
- BaseAddr, 32'h0000_0000, DCCM byte base address, aligned to 2^(AddrWidth+2).

Ports:
- brq_clk  in  1  clock, rising edge.
- brq_rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises rsp_error.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned, out-of-range or illegal size.
- dccm_byte_enable  out  3  lane code to DCCM.
- dccm_address  out  AddrWidth  DCCM word index.
- dccm_data_in  out  32  store data to DCCM.
- dccm_write_enable  out  1  DCCM write strobe.
- dccm_read_enable  out  1  DCCM read strobe.
- dccm_data_out  in  32  DCCM read word, combinational from dccm_address.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_error=0; all dccm_* outputs 0.
- Async reset mid-ACCESS drops dccm_write_enable at once; that store is not committed.
- All dccm_* outputs are registered and stable for the whole ACCESS cycle. The DCCM merges lanes combinationally and writes at the next edge.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready=1.
  - On valid&ready, register the request.
  - If the request is faulty, go to RESP with rsp_error=1 and issue no DCCM strobe.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - req_ready=0.
  - write_enable = registered we; read_enable = !we.
  - At the closing edge, extract dccm_data_out into rsp_rdata (loads) and go to RESP.
- RESP:
  - rsp_valid=1; hold rsp_valid, rsp_rdata and rsp_error stable until rsp_ready.
  - On rsp_ready go to IDLE; req_ready rises the next cycle.
- In non-ACCESS states both strobes are 0; address, byte_enable and data_in hold their last values.
- Latency: handshake at edge N -> strobes during cycle N+1 -> rsp_valid from edge N+2. Peak throughput is 1 request per 3 cycles.
- Faults:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2].
  - Illegal size: req_size==3.
- dccm_address = req_addr[AddrWidth+1:2].
- Byte-enable codes:
  - Byte store: addr[1:0] -> 000/001/010/011 (lane 0..3).
  - Half store: addr[1]=0 -> 101 (bits 15:0); addr[1]=1 -> 100 (bits 31:16).
  - Word store: 110.
  - Loads drive the same code; the DCCM ignores it on reads.
- dccm_data_in = req_wdata, unshifted. The DCCM takes byte stores from data_in[7:0] and half stores from data_in[15:0], whatever the lane.
- Load extraction:
  - Byte: select lane addr[1:0], i.e. bits [8*k+7:8*k].
  - Half: select [15:0] if addr[1]=0, else [31:16].
  - Word: pass through.
  - Sign-extend from the MSB of the selected field unless req_unsigned; word loads ignore req_unsigned.
- Stores return rsp_rdata=0 and rsp_error=0.
- req_valid while req_ready=0 is ignored; the requester must hold its request stable until accepted.

Decomposition:
- Package brq_lsu_pkg:
  - enum lsu_size_e {LSU_B, LSU_H, LSU_W}.
  - localparams BE_B0..BE_B3 (3'b000..3'b011), BE_HHI (3'b100), BE_HLO (3'b101), BE_W (3'b110).
  - enum lsu_state_e {IDLE, ACCESS, RESP}.
  - A req_t struct {we, size, unsigned, addr, wdata}.
- Sub-module dccm_lsu_rdext: combinational lane select and extend from (word, addr[1:0], size, unsigned).
- The top level holds the FSM, fault check, byte-enable encode and registers.

Test Plan:
- Reset: assert brq_rst_n=0 mid-ACCESS of a word store -> strobes drop asynchronously, memory word unchanged, state IDLE, req_ready=1 after release.
- Byte store then loads:
  - SB 0xA5 to addr 0x6 -> byte_enable=010, dccm_address=1, one write cycle.
  - Then LB from 0x6 -> rsp_rdata=0xFFFF_FFA5.
  - LBU from 0x6 -> 0x0000_00A5.
- Half stores:
  - SH 0x8001 to 0xA -> byte_enable=100.
  - SH 0x1234 to 0x8 -> byte_enable=101.
  - LW from 0x8 -> 0x8001_1234; LH from 0xA -> 0xFFFF_8001.
- Misaligned and out-of-range:
  - LW from 0x2 -> rsp_error=1, rsp_rdata=0, no strobe.
  - SH to 0x3 -> rsp_error=1, no strobe.
  - Address 0x0002_0000 with AddrWidth=15 -> rsp_error=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after an LW -> rsp_valid and rsp_rdata stable, req_ready=0, no new strobes; rsp_ready=1 -> IDLE next cycle.
- Back-to-back: 8 random SW/LW pairs with req_valid held high -> one request per 3 cycles, read data matches a scoreboard.

Source files
------------

// File: rtl/dccm_lsu_pkg.sv
// Shared types and encodings for the DCCM load/store initiator.
// Holds access sizes, byte-lane codes, FSM states and the request bundle.
package brq_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] BE_B0  = 3'b000;
    localparam logic [2:0] BE_B1  = 3'b001;
    localparam logic [2:0] BE_B2  = 3'b010;
    localparam logic [2:0] BE_B3  = 3'b011;
    localparam logic [2:0] BE_HHI = 3'b100;
    localparam logic [2:0] BE_HLO = 3'b101;
    localparam logic [2:0] BE_W   = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Loads drive the same lane code as stores; the DCCM ignores it on reads.
    function automatic logic [2:0] be_encode(input logic [1:0] size, input logic [1:0] off);
        logic [2:0] be;
        case (size)
            LSU_B: begin
                case (off)
                    2'd0:    be = BE_B0;
                    2'd1:    be = BE_B1;
                    2'd2:    be = BE_B2;
                    default: be = BE_B3;
                endcase
            end
            LSU_H:   be = off[1] ? BE_HHI : BE_HLO;
            default: be = BE_W;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_H) && off[0]) || ((size == LSU_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dccm_lsu_rdext.sv
// Lane select and sign/zero extension of a DCCM read word.
// Purely combinational; word loads pass through regardless of unsigned_i.
module dccm_lsu_rdext
    import brq_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = word_i;
        case (size_i)
            LSU_B:   data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            LSU_H:   data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dccm_lsu.sv
// Load/store initiator for the single-port DCCM: accepts one request, checks it,
// drives one registered access cycle and returns a backpressurable response.
module dccm_lsu
    import brq_lsu_pkg::*;
#(
    parameter int          DataWidth = 32,
    parameter int          AddrWidth = 15,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic [2:0]           dccm_byte_enable,
    output logic [AddrWidth-1:0] dccm_address,
    output logic [DataWidth-1:0] dccm_data_in,
    output logic                 dccm_write_enable,
    output logic                 dccm_read_enable,
    input  logic [DataWidth-1:0] dccm_data_out
);

    lsu_state_e state_q, state_d;

    req_t req_in;
    logic accept;
    logic fault;

    logic                 we_q,       we_d;
    logic [1:0]           size_q,     size_d;
    logic                 uns_q,      uns_d;
    logic [1:0]           off_q,      off_d;
    logic [DataWidth-1:0] rdata_q,    rdata_d;
    logic                 error_q,    error_d;
    logic [2:0]           be_q,       be_d;
    logic [AddrWidth-1:0] addr_q,     addr_d;
    logic [DataWidth-1:0] wdata_q,    wdata_d;
    logic                 wr_en_q,    wr_en_d;
    logic                 rd_en_q,    rd_en_d;
    logic [DataWidth-1:0] ext_data;

    assign req_in = '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                      addr: req_addr, wdata: req_wdata};

    assign accept = req_valid && req_ready;
    assign fault  = (req_in.size == 2'd3)
                 || is_misaligned(req_in.size, req_in.addr[1:0])
                 || (req_in.addr[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2]);

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fault ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Faulty requests update only the response; DCCM outputs keep their last values.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        error_d = error_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = wr_en_q;
        rd_en_d = rd_en_q;
        if (accept) begin
            we_d   = req_in.we;
            size_d = req_in.size;
            uns_d  = req_in.is_unsigned;
            off_d  = req_in.addr[1:0];
            if (fault) begin
                error_d = 1'b1;
                rdata_d = '0;
            end else begin
                be_d    = be_encode(req_in.size, req_in.addr[1:0]);
                addr_d  = req_in.addr[AddrWidth+1:2];
                wdata_d = req_in.wdata;
                wr_en_d = req_in.we;
                rd_en_d = !req_in.we;
            end
        end else if (state_q == ACCESS) begin
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
            error_d = 1'b0;
            rdata_d = we_q ? '0 : ext_data;
        end
    end

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            rdata_q <= '0;
            error_q <= 1'b0;
            be_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
        end
    end

    dccm_lsu_rdext u_rdext (
        .word_i     (dccm_data_out),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign rsp_rdata         = rdata_q;
    assign rsp_error         = error_q;
    assign dccm_byte_enable  = be_q;
    assign dccm_address      = addr_q;
    assign dccm_data_in      = wdata_q;
    assign dccm_write_enable = wr_en_q;
    assign dccm_read_enable  = rd_en_q;

endmodule

// File: tb/tb_dccm_lsu.sv
// Directed bench for dccm_lsu with a behavioural lane-merging DCCM model.
module tb_dccm_lsu;

    localparam int AW = 15;

    logic          brq_clk = 1'b0;
    logic          brq_rst_n = 1'b0;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready, rsp_error;
    logic [31:0]   rsp_rdata;
    logic [2:0]    dccm_byte_enable;
    logic [AW-1:0] dccm_address;
    logic [31:0]   dccm_data_in, dccm_data_out;
    logic          dccm_write_enable, dccm_read_enable;

    always #5 brq_clk = ~brq_clk;

    dccm_lsu #(.DataWidth(32), .AddrWidth(AW), .BaseAddr(32'h0)) dut (
        .brq_clk           (brq_clk),
        .brq_rst_n         (brq_rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_error         (rsp_error),
        .dccm_byte_enable  (dccm_byte_enable),
        .dccm_address      (dccm_address),
        .dccm_data_in      (dccm_data_in),
        .dccm_write_enable (dccm_write_enable),
        .dccm_read_enable  (dccm_read_enable),
        .dccm_data_out     (dccm_data_out)
    );

    // DCCM model: lanes merged combinationally, written at the clock edge.
    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] be, input logic [31:0] d);
        case (be)
            3'b000:  return {old[31:8], d[7:0]};
            3'b001:  return {old[31:16], d[7:0], old[7:0]};
            3'b010:  return {old[31:24], d[7:0], old[15:0]};
            3'b011:  return {d[7:0], old[23:0]};
            3'b100:  return {d[15:0], old[15:0]};
            3'b101:  return {old[31:16], d[15:0]};
            3'b110:  return d;
            default: return old;
        endcase
    endfunction

    assign dccm_data_out = mem[dccm_address];
    always @(posedge brq_clk)
        if (dccm_write_enable) mem[dccm_address] <= merge(mem[dccm_address], dccm_byte_enable, dccm_data_in);

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wr, output int rd, output logic [2:0] be, output logic [AW-1:0] ad);
        wr = 0; rd = 0; lat = 0; be = 3'd0; ad = '0; rdata = 32'h0; err = 1'b0;
        @(negedge brq_clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge brq_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (dccm_write_enable) wr++;
            if (dccm_read_enable)  rd++;
            if (dccm_write_enable || dccm_read_enable) begin
                be = dccm_byte_enable;
                ad = dccm_address;
            end
            @(negedge brq_clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_error;
        rsp_ready = 1'b1;
        @(negedge brq_clk);
        rsp_ready = 1'b0;
        $display("req we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    logic [31:0]   rdv;
    logic          erv;
    int            lat, wr, rd;
    logic [2:0]    bev;
    logic [AW-1:0] adv;

    logic        b_we [16];
    logic [31:0] b_ad [16];
    logic [31:0] b_wd [16];
    logic [31:0] b_exp [16];
    logic [31:0] sb [4];
    int          acc_cyc [16];

    task automatic drive_b2b(input int i);
        req_we = b_we[i]; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = b_ad[i]; req_wdata = b_wd[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("rst_dccm_out", {dccm_data_in | 32'(dccm_address) | 32'(dccm_byte_enable)}, 32'h0);
        chk("rst_strobes", 32'({dccm_write_enable, dccm_read_enable}), 32'h0);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;

        // Byte store then signed/unsigned byte loads
        do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00A5, rdv, erv, lat, wr, rd, bev, adv);
        chk("sb_be", 32'(bev), 32'h2);
        chk("sb_addr", 32'(adv), 32'h1);
        chk("sb_wr_cycles", 32'(wr), 32'h1);
        chk("sb_rd_cycles", 32'(rd), 32'h0);
        chk("sb_latency", 32'(lat), 32'h2);
        chk("sb_rsp", {rdv[30:0], erv}, 32'h0);
        chk("sb_mem", mem[1], 32'h00A5_0000);
        do_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lb_rdata", rdv, 32'hFFFF_FFA5);
        chk("lb_rd_cycles", 32'(rd), 32'h1);
        chk("lb_wr_cycles", 32'(wr), 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h6, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lbu_rdata", rdv, 32'h0000_00A5);

        // Half stores and loads
        do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_8001, rdv, erv, lat, wr, rd, bev, adv);
        chk("sh_hi_be", 32'(bev), 32'h4);
        chk("sh_hi_addr", 32'(adv), 32'h2);
        chk("sh_hi_rdata_zero", rdv, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h8, 32'h0000_1234, rdv, erv, lat, wr, rd, bev, adv);
        chk("sh_lo_be", 32'(bev), 32'h5);
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lw_rdata", rdv, 32'h8001_1234);
        chk("lw_be", 32'(bev), 32'h6);
        do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lh_hi_rdata", rdv, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lhu_hi_rdata", rdv, 32'h0000_8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lh_lo_rdata", rdv, 32'h0000_1234);
        do_req(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lb_lane3_rdata", rdv, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lbu_lane1_rdata", rdv, 32'h0000_0012);

        // Faults: no strobe, error response one cycle after handshake
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("lw_mis_err", 32'(erv), 32'h1);
        chk("lw_mis_rdata", rdv, 32'h0);
        chk("lw_mis_strobes", 32'(wr + rd), 32'h0);
        chk("lw_mis_latency", 32'(lat), 32'h1);
        do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000_FFFF, rdv, erv, lat, wr, rd, bev, adv);
        chk("sh_mis_err", 32'(erv), 32'h1);
        chk("sh_mis_strobes", 32'(wr + rd), 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("oor_err", 32'(erv), 32'h1);
        chk("oor_strobes", 32'(wr + rd), 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("size3_err", 32'(erv), 32'h1);
        chk("addr_hold_after_fault", 32'(dccm_address), 32'h2);
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("err_clears", 32'(erv), 32'h0);

        // Backpressure on a load response
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rdv, erv, lat, wr, rd, bev, adv);
        @(negedge brq_clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(negedge brq_clk);
        req_valid = 1'b0;
        @(negedge brq_clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_no_strobe", 32'({dccm_write_enable, dccm_read_enable}), 32'h0);
            @(negedge brq_clk);
        end
        rsp_ready = 1'b1;
        @(negedge brq_clk);
        rsp_ready = 1'b0;
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        $display("backpressure load addr=00000010 held 5 cycles");

        // Asynchronous reset in the middle of a word store
        @(negedge brq_clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h5566_7788; req_valid = 1'b1;
        @(negedge brq_clk);
        req_valid = 1'b0;
        chk("mid_rst_we_before", 32'(dccm_write_enable), 32'h1);
        #1 brq_rst_n = 1'b0;
        #1;
        chk("mid_rst_we_drop", 32'(dccm_write_enable), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        chk("mid_rst_mem", mem[8], 32'h0);
        $display("reset mid-access store addr=00000020 aborted");
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rdv, erv, lat, wr, rd, bev, adv);
        chk("mid_rst_reload", rdv, 32'h0);

        // Back-to-back SW/LW pairs with req_valid held high
        for (int k = 0; k < 4; k++) sb[k] = 32'h0;
        for (int p = 0; p < 8; p++) begin
            int ks, kl;
            ks = int'($urandom_range(0, 3));
            kl = int'($urandom_range(0, 3));
            b_we[2*p] = 1'b1;   b_ad[2*p] = 32'h80 + 32'(4*ks); b_wd[2*p] = $urandom;
            sb[ks] = b_wd[2*p]; b_exp[2*p] = 32'h0;
            b_we[2*p+1] = 1'b0; b_ad[2*p+1] = 32'h80 + 32'(4*kl); b_wd[2*p+1] = 32'h0;
            b_exp[2*p+1] = sb[kl];
        end
        begin
            int  idx;
            int  nrsp;
            bit  advance;
            idx = 0; nrsp = 0; advance = 1'b0;
            drive_b2b(0);
            req_valid = 1'b1;
            rsp_ready = 1'b1;
            for (int cyc = 0; cyc < 200 && nrsp < 16; cyc++) begin
                if (advance) begin
                    idx++;
                    advance = 1'b0;
                    if (idx < 16) drive_b2b(idx);
                    else req_valid = 1'b0;
                end
                if (rsp_valid) begin
                    chk("b2b_rdata", rsp_rdata, b_exp[nrsp]);
                    chk("b2b_err", 32'(rsp_error), 32'h0);
                    $display("b2b rsp %0d we=%0d addr=%h rdata=%h", nrsp, b_we[nrsp], b_ad[nrsp], rsp_rdata);
                    nrsp++;
                end
                if (req_valid && req_ready) begin
                    acc_cyc[idx] = cyc;
                    advance = 1'b1;
                end
                @(negedge brq_clk);
            end
            rsp_ready = 1'b0;
            req_valid = 1'b0;
            chk("b2b_done", 32'(nrsp), 32'd16);
            for (int i = 1; i < 16; i++)
                chk("b2b_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
